// File: rtl/page_digits_editor.sv
// Config page renderer: background image plus NUM_DIGITS scaled hex glyphs.
// In edit mode, keys move a blinking cursor and step the selected nibble.
module page_digits_editor #(
  parameter int          NUM_DIGITS   = 4,
  parameter int          GLYPH_W      = 16,
  parameter int          GLYPH_H      = 32,
  parameter int          SCALE_LOG2   = 1,
  parameter int          X0           = 256,
  parameter int          Y0           = 176,
  parameter logic [11:0] FG_COLOR     = 12'h000,
  parameter logic [11:0] CUR_COLOR    = 12'h00F,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    vga_clk,
  input  logic                    vga_rst,
  input  logic [9:0]              x_pos,
  input  logic [9:0]              y_pos,
  input  logic [4:0]              keys,
  input  logic                    edit_en,
  input  logic [4*NUM_DIGITS-1:0] disp_num,
  output logic [18:0]             bg_addr,
  input  logic [11:0]             bg_data,
  output logic [15:0]             font_addr,
  input  logic                    font_bit,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [2:0]              cursor_idx,
  output logic [11:0]             pixel_data
);

  localparam int NW     = 4 * NUM_DIGITS;
  localparam int CELL_W = GLYPH_W << SCALE_LOG2;
  localparam int BOX_W  = NUM_DIGITS * CELL_W;
  localparam int BOX_H  = GLYPH_H << SCALE_LOG2;
  localparam int CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]   X_LO      = 11'(X0);
  localparam logic [10:0]   X_HI      = 11'(X0 + BOX_W);
  localparam logic [10:0]   Y_LO      = 11'(Y0);
  localparam logic [10:0]   Y_HI      = 11'(Y0 + BOX_H);
  localparam logic [9:0]    CELL_W_V  = 10'(CELL_W);
  localparam logic [9:0]    GLYPH_W_V = 10'(GLYPH_W);
  localparam logic [15:0]   GLYPH_W16 = 16'(GLYPH_W);
  localparam logic [15:0]   ROW_16    = 16'(16 * GLYPH_W);
  localparam logic [2:0]    MAX_CUR   = 3'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_FR   = CW'(BLINK_FRAMES - 1);

  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_INC   = 2;
  localparam int K_DEC   = 3;
  localparam int K_LOAD  = 4;

  logic [NW-1:0] r_value;
  logic [2:0]    r_cursor;
  logic [4:0]    r_keys_prev;
  logic          r_origin_prev;
  logic          r_blink_on;
  logic [CW-1:0] r_frame_cnt;
  logic          r_in_box;
  logic          r_cursor_digit;
  logic          r_visible;
  logic [11:0]   r_pixel;

  logic          w_visible;
  logic          w_in_box;
  logic [9:0]    w_dx;
  logic [9:0]    w_dy;
  logic [9:0]    w_pos;
  logic [9:0]    w_gx;
  logic [9:0]    w_gy;
  logic [NW-1:0] w_src;
  logic [3:0]    w_nib;
  logic [18:0]   w_bg_addr;
  logic          w_cursor_hit;
  logic [4:0]    w_act;
  logic [NW-1:0] w_value_nxt;
  logic          w_val_chg;
  logic [2:0]    w_cursor_nxt;
  logic          w_move;
  logic          w_tick;
  logic [11:0]   w_pixel;

  assign value_out  = r_value;
  assign cursor_idx = r_cursor;
  assign pixel_data = r_pixel;

  // Address generation: purely combinational so the ROM read lines up with stage 1.
  always_comb begin
    w_visible = (x_pos < 10'd640) && (y_pos < 10'd480);
    w_in_box  = w_visible &&
                ({1'b0, x_pos} >= X_LO) && ({1'b0, x_pos} < X_HI) &&
                ({1'b0, y_pos} >= Y_LO) && ({1'b0, y_pos} < Y_HI);
    w_dx  = x_pos - X_LO[9:0];
    w_dy  = y_pos - Y_LO[9:0];
    w_pos = w_dx / CELL_W_V;
    w_gx  = (w_dx >> SCALE_LOG2) % GLYPH_W_V;
    w_gy  = w_dy >> SCALE_LOG2;
    w_src = edit_en ? r_value : disp_num;
    w_nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_pos == 10'(NUM_DIGITS - 1 - i)) w_nib = w_src[i*4 +: 4];
    end
    w_bg_addr    = 19'(x_pos) + 19'(y_pos) * 19'd640;
    bg_addr      = w_visible ? w_bg_addr : 19'd0;
    font_addr    = w_in_box ? (16'(w_nib) * GLYPH_W16 + 16'(w_gx) + 16'(w_gy) * ROW_16) : 16'd0;
    w_cursor_hit = w_in_box && (w_pos == 10'(r_cursor));
  end

  // Key actions: only fresh rising edges count, and only in edit mode.
  always_comb begin
    w_act        = edit_en ? (keys & ~r_keys_prev) : 5'd0;
    w_value_nxt  = r_value;
    w_val_chg    = 1'b0;
    w_cursor_nxt = r_cursor;
    w_move       = 1'b0;
    if (w_act[K_LOAD]) begin
      w_value_nxt = disp_num;
      w_val_chg   = 1'b1;
    end else if (w_act[K_INC] ^ w_act[K_DEC]) begin
      w_val_chg = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_cursor == 3'(NUM_DIGITS - 1 - i)) begin
          if (w_act[K_INC]) w_value_nxt[i*4 +: 4] = r_value[i*4 +: 4] + 4'd1;
          else              w_value_nxt[i*4 +: 4] = r_value[i*4 +: 4] - 4'd1;
        end
      end
    end
    if (w_act[K_LEFT] ^ w_act[K_RIGHT]) begin
      w_move = 1'b1;
      if (w_act[K_LEFT]) w_cursor_nxt = (r_cursor == 3'd0) ? MAX_CUR : r_cursor - 3'd1;
      else               w_cursor_nxt = (r_cursor == MAX_CUR) ? 3'd0 : r_cursor + 3'd1;
    end
    w_tick = (x_pos == 10'd0) && (y_pos == 10'd0) && !r_origin_prev;
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r_value       <= '0;
      r_cursor      <= 3'd0;
      r_keys_prev   <= 5'd0;
      r_origin_prev <= 1'b0;
      r_blink_on    <= 1'b1;
      r_frame_cnt   <= '0;
    end else begin
      r_value       <= w_value_nxt;
      r_cursor      <= w_cursor_nxt;
      r_keys_prev   <= keys;
      r_origin_prev <= (x_pos == 10'd0) && (y_pos == 10'd0);
      // Any edit restarts the blink so the cursor is shown straight away.
      if (w_val_chg || w_move) begin
        r_blink_on  <= 1'b1;
        r_frame_cnt <= '0;
      end else if (w_tick) begin
        if (r_frame_cnt == LAST_FR) begin
          r_frame_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pixel = bg_data;
    if (!r_visible)
      w_pixel = 12'd0;
    else if (r_in_box && font_bit && r_cursor_digit && edit_en && r_blink_on)
      w_pixel = CUR_COLOR;
    else if (r_in_box && font_bit)
      w_pixel = FG_COLOR;
  end

  // Stage 1 travels alongside the ROM read, stage 2 is the output pixel.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      r_in_box       <= 1'b0;
      r_cursor_digit <= 1'b0;
      r_visible      <= 1'b0;
      r_pixel        <= 12'd0;
    end else begin
      r_in_box       <= w_in_box;
      r_cursor_digit <= w_cursor_hit;
      r_visible      <= w_visible;
      r_pixel        <= w_pixel;
    end
  end

endmodule

// File: tb/tb_page_digits_editor.sv
// Directed bench for page_digits_editor: pixel scans against a reference model,
// a key-action vector table, and blink / reset sequences.
module tb_page_digits_editor;

  localparam int          ND  = 4;
  localparam int          GW  = 16;
  localparam int          GH  = 32;
  localparam int          SL  = 1;
  localparam int          X0  = 256;
  localparam int          Y0  = 176;
  localparam int          BF  = 2;
  localparam logic [11:0] FG  = 12'h8C1;
  localparam logic [11:0] CUR = 12'h00F;
  localparam int          CELL  = GW << SL;
  localparam int          BOX_W = ND * CELL;
  localparam int          BOX_H = GH << SL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    x_pos = 10'd700;
  logic [9:0]    y_pos = 10'd500;
  logic [4:0]    keys = 5'd0;
  logic          edit_en = 1'b0;
  logic [15:0]   disp_num = 16'h1A3F;
  logic [18:0]   bg_addr;
  logic [11:0]   bg_data = 12'd0;
  logic [15:0]   font_addr;
  logic          font_bit = 1'b0;
  logic [15:0]   value_out;
  logic [2:0]    cursor_idx;
  logic [11:0]   pixel_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_value;
  logic [15:0] m_disp;
  int          m_cursor;
  bit          m_edit;
  bit          m_blink;
  int          m_cnt;

  typedef struct {
    logic [4:0]  k;
    logic        ed;
    logic [15:0] disp;
    logic [15:0] ev;
    logic [2:0]  ec;
  } kvec_t;
  kvec_t kt[16];

  page_digits_editor #(
    .NUM_DIGITS(ND), .GLYPH_W(GW), .GLYPH_H(GH), .SCALE_LOG2(SL), .X0(X0), .Y0(Y0),
    .FG_COLOR(FG), .CUR_COLOR(CUR), .BLINK_FRAMES(BF)
  ) dut (
    .vga_clk(clk), .vga_rst(rst), .x_pos(x_pos), .y_pos(y_pos), .keys(keys),
    .edit_en(edit_en), .disp_num(disp_num), .bg_addr(bg_addr), .bg_data(bg_data),
    .font_addr(font_addr), .font_bit(font_bit), .value_out(value_out),
    .cursor_idx(cursor_idx), .pixel_data(pixel_data)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bg_fn(input int a);
    return 12'(a ^ (a >> 7) ^ 'h5A3);
  endfunction

  function automatic logic font_fn(input int a);
    logic [15:0] v;
    v = 16'(a);
    return v[0] ^ v[2] ^ v[4] ^ v[5] ^ v[7] ^ v[9] ^ v[12];
  endfunction

  // One-cycle-latency ROMs.
  always @(posedge clk) begin
    bg_data  <= bg_fn(int'(bg_addr));
    font_bit <= font_fn(int'(font_addr));
  end

  function automatic bit vis(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  function automatic bit in_box(input int x, input int y);
    return vis(x, y) && x >= X0 && x < X0 + BOX_W && y >= Y0 && y < Y0 + BOX_H;
  endfunction

  function automatic int nib_at(input int pos);
    logic [15:0] src;
    src = m_edit ? m_value : m_disp;
    return int'((src >> (4 * (ND - 1 - pos))) & 16'hF);
  endfunction

  function automatic int exp_font_addr(input int x, input int y);
    int dx, dy;
    if (!in_box(x, y)) return 0;
    dx = x - X0;
    dy = y - Y0;
    return nib_at(dx / CELL) * GW + ((dx >> SL) % GW) + (dy >> SL) * 16 * GW;
  endfunction

  function automatic int exp_bg_addr(input int x, input int y);
    return vis(x, y) ? x + y * 640 : 0;
  endfunction

  function automatic logic [11:0] exp_pixel(input int x, input int y);
    if (!vis(x, y)) return 12'd0;
    if (!in_box(x, y) || !font_fn(exp_font_addr(x, y))) return bg_fn(x + y * 640);
    if ((x - X0) / CELL == m_cursor && m_edit && m_blink) return CUR;
    return FG;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    x_pos = 10'd700;
    y_pos = 10'd500;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    x_pos = 10'd300;
    y_pos = 10'd200;
    @(negedge clk);
    rst = 1'b0;
    idle();
    m_value = 16'h0; m_cursor = 0; m_blink = 1'b1; m_cnt = 0;
    chk({name, " pixel"}, 32'(pixel_data), 32'h0);
    chk({name, " value"}, 32'(value_out), 32'h0);
    chk({name, " cursor"}, 32'(cursor_idx), 32'h0);
  endtask

  task automatic probe(input int x, input int y, input string name);
    logic [11:0] e;
    @(negedge clk);
    x_pos = 10'(x);
    y_pos = 10'(y);
    e = exp_pixel(x, y);
    #1;
    chk({name, " bg_addr"}, 32'(bg_addr), 32'(exp_bg_addr(x, y)));
    chk({name, " font_addr"}, 32'(font_addr), 32'(exp_font_addr(x, y)));
    @(negedge clk);
    idle();
    @(negedge clk);
    chk({name, " pixel"}, 32'(pixel_data), 32'(e));
  endtask

  task automatic scan(input int y, input int xs, input int xe);
    logic [11:0] exp_q[$];
    for (int x = xs; x <= xe + 2; x++) begin
      @(negedge clk);
      if (x >= xs + 2)
        chk($sformatf("scan(%0d,%0d)", x - 2, y), 32'(pixel_data), 32'(exp_q.pop_front()));
      if (x <= xe) begin
        x_pos = 10'(x);
        y_pos = 10'(y);
        exp_q.push_back(exp_pixel(x, y));
      end else begin
        idle();
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    x_pos = 10'd0;
    y_pos = 10'd0;
    @(negedge clk);
    idle();
    if (m_cnt == BF - 1) begin
      m_cnt = 0;
      m_blink = !m_blink;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    keys = k;
    @(negedge clk);
    keys = 5'd0;
  endtask

  task automatic find_px(output int fx, output int fy);
    bit ok;
    ok = 1'b0;
    fx = X0;
    fy = Y0;
    for (int yy = Y0; yy < Y0 + BOX_H; yy++)
      for (int xx = X0 + m_cursor * CELL; xx < X0 + (m_cursor + 1) * CELL; xx++)
        if (!ok && font_fn(exp_font_addr(xx, yy))) begin
          fx = xx; fy = yy; ok = 1'b1;
        end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL find_px: no glyph pixel in cursor cell %0d", m_cursor);
    end
  endtask

  initial begin
    int px, py, ly;
    kt[0]  = '{5'd16, 1'b1, 16'h00F0, 16'h00F0, 3'd0};
    kt[1]  = '{5'd2,  1'b1, 16'h00F0, 16'h00F0, 3'd1};
    kt[2]  = '{5'd2,  1'b1, 16'h00F0, 16'h00F0, 3'd2};
    kt[3]  = '{5'd4,  1'b1, 16'h00F0, 16'h0000, 3'd2};
    kt[4]  = '{5'd8,  1'b1, 16'h00F0, 16'h00F0, 3'd2};
    kt[5]  = '{5'd8,  1'b1, 16'h00F0, 16'h00E0, 3'd2};
    kt[6]  = '{5'd1,  1'b1, 16'h00F0, 16'h00E0, 3'd1};
    kt[7]  = '{5'd1,  1'b1, 16'h00F0, 16'h00E0, 3'd0};
    kt[8]  = '{5'd1,  1'b1, 16'h00F0, 16'h00E0, 3'd3};
    kt[9]  = '{5'd14, 1'b1, 16'h00F0, 16'h00E0, 3'd0};
    kt[10] = '{5'd20, 1'b1, 16'h1234, 16'h1234, 3'd0};
    kt[11] = '{5'd3,  1'b1, 16'h1234, 16'h1234, 3'd0};
    kt[12] = '{5'd4,  1'b1, 16'h1234, 16'h2234, 3'd0};
    kt[13] = '{5'd22, 1'b0, 16'hABCD, 16'h2234, 3'd0};
    kt[14] = '{5'd9,  1'b0, 16'hABCD, 16'h2234, 3'd0};
    kt[15] = '{5'd8,  1'b1, 16'hABCD, 16'h1234, 3'd0};

    m_edit = 1'b0;
    m_disp = 16'h1A3F;
    do_reset("reset0");

    // Display mode scan of the digit box and margins.
    for (int y = Y0 - 4; y < Y0 + BOX_H + 4; y++) scan(y, X0 - 6, X0 + BOX_W + 6);
    scan(200, 630, 645);
    scan(479, 0, 4);
    scan(480, 0, 4);

    // Latency: find a row whose pixel at x=300 is a glyph pixel.
    ly = -1;
    for (int y = Y0; y < Y0 + BOX_H; y++)
      if (ly < 0 && exp_pixel(300, y) == FG) ly = y;
    if (ly < 0) begin
      n_tests++; n_fail++;
      $display("FAIL latency: no glyph pixel at x=300");
    end else begin
      @(negedge clk); x_pos = 10'd300; y_pos = 10'(ly);
      @(negedge clk); x_pos = 10'd301;
      chk("latency c1", 32'(pixel_data), 32'h0);
      @(negedge clk); idle();
      chk("latency c2", 32'(pixel_data), 32'(FG));
      @(negedge clk);
      chk("latency c3", 32'(pixel_data), 32'(exp_pixel(301, ly)));
    end

    // Key action table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      keys = kt[i].k;
      edit_en = kt[i].ed;
      disp_num = kt[i].disp;
      @(negedge clk);
      chk($sformatf("key[%0d] value", i), 32'(value_out), 32'(kt[i].ev));
      chk($sformatf("key[%0d] cursor", i), 32'(cursor_idx), 32'(kt[i].ec));
      keys = 5'd0;
    end

    // Held inc acts once.
    @(negedge clk);
    keys = 5'd4;
    repeat (100) @(negedge clk);
    chk("held value", 32'(value_out), 32'h2234);
    keys = 5'd0;
    @(negedge clk);
    chk("held release", 32'(value_out), 32'h2234);

    // Blink.
    edit_en = 1'b1;
    m_edit = 1'b1;
    disp_num = 16'h5678;
    m_disp = 16'h5678;
    do_reset("reset1");
    find_px(px, py);
    probe(px, py, "blink f0");
    for (int f = 1; f <= 8; f++) begin
      tick();
      probe(px, py, $sformatf("blink f%0d", f));
    end
    tick();
    tick();
    probe(px, py, "blink off");
    chk("blink off model", 32'(m_blink), 32'h0);
    press(5'd4);
    m_value = 16'h1000; m_blink = 1'b1; m_cnt = 0;
    find_px(px, py);
    probe(px, py, "inc forces on");

    // Edit disabled: keys ignored, no cursor colour.
    edit_en = 1'b0;
    m_edit = 1'b0;
    press(5'd31);
    chk("noedit value", 32'(value_out), 32'h1000);
    chk("noedit cursor", 32'(cursor_idx), 32'h0);
    find_px(px, py);
    probe(px, py, "noedit pixel");

    // Reset mid-frame after edits with blink off.
    edit_en = 1'b1;
    m_edit = 1'b1;
    press(5'd2);
    press(5'd4);
    m_cursor = 1; m_value = 16'h1100; m_blink = 1'b1; m_cnt = 0;
    chk("pre-reset value", 32'(value_out), 32'h1100);
    chk("pre-reset cursor", 32'(cursor_idx), 32'h1);
    tick();
    tick();
    find_px(px, py);
    probe(px, py, "pre-reset off");
    do_reset("reset2");
    find_px(px, py);
    probe(px, py, "post-reset blink");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
